// File: rtl/dco_clock_pkg.sv
// clock_settings: shared emulated-time formats, LFSR polynomial,
// link-rate periods and per-phase step math for the DCO clocks.
package clock_settings;

  localparam int TIME_BITS   = 32;
  localparam int PERIOD_BITS = 16;

  typedef logic [TIME_BITS-1:0]   TIME_FORMAT;
  typedef logic [PERIOD_BITS-1:0] PERIOD_FORMAT;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1, right-shifting
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  localparam PERIOD_FORMAT PERIOD_5G  = 16'd2000;
  localparam PERIOD_FORMAT PERIOD_10G = 16'd1000;
  localparam PERIOD_FORMAT PERIOD_20G = 16'd500;
  localparam PERIOD_FORMAT PERIOD_25G = 16'd400;

  // Last phase absorbs the remainder so a period sums exactly.
  function automatic logic [31:0] phase_step(
    input logic [31:0] period,
    input logic [31:0] phase,
    input logic [31:0] n_phase
  );
    logic [31:0] base;
    logic [31:0] last;
    case (n_phase)
      32'd2:   base = period >> 1;
      32'd4:   base = period >> 2;
      32'd8:   base = period >> 3;
      default: base = period;
    endcase
    last = period - (n_phase - 32'd1) * base;
    phase_step = (phase == n_phase - 32'd1) ? last : base;
  endfunction

endpackage

// File: rtl/dco_clock_lfsr.sv
// jitter_lfsr: 16-bit Galois LFSR giving a signed per-edge jitter
// word; collapses to a constant zero when JITTER_W is 0.
module jitter_lfsr
  import clock_settings::*;
#(
  parameter int          JITTER_W = 0,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          OUT_W    = 34
)(
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             adv,
  output logic [OUT_W-1:0] jit
);

  if (JITTER_W == 0) begin : g_off
    logic unused_in;
    assign unused_in = ^{clk_sys, rst_n, adv};
    assign jit = '0;
  end else begin : g_on
    logic [15:0] lfsr;

    always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
        lfsr <= SEED;
      end else if (adv) begin
        lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : 16'h0);
      end
    end

    assign jit = OUT_W'($signed(lfsr[JITTER_W-1:0]));
  end

endmodule

// File: rtl/dco_clock.sv
// dco_clock: emulated-time clock with N_PHASE edges per period,
// CDR/load period control and optional per-edge LFSR jitter.
module dco_clock
  import clock_settings::*;
#(
  parameter int                  TIME_W      = 32,
  parameter int                  PERIOD_W    = 16,
  parameter int                  N_PHASE     = 2,
  parameter logic [PERIOD_W-1:0] PERIOD_INIT = 16'd1000,
  parameter logic [PERIOD_W-1:0] PERIOD_MIN  = 16'd900,
  parameter logic [PERIOD_W-1:0] PERIOD_MAX  = 16'd1100,
  parameter logic [PERIOD_W-1:0] STEP        = 16'd1,
  parameter int                  JITTER_W    = 0,
  parameter logic [15:0]         LFSR_SEED   = 16'hACE1,
  parameter logic [TIME_W-1:0]   TIME_INIT   = '0
)(
  input  logic                clk_sys,
  input  logic                rst_n,
  input  logic                en,
  input  logic [TIME_W-1:0]   time_next,
  input  logic                up,
  input  logic                dn,
  input  logic                period_load,
  input  logic [PERIOD_W-1:0] period_val,
  output logic [TIME_W-1:0]   time_clock,
  output logic                time_eq,
  output logic [N_PHASE-1:0]  phase_edge,
  output logic [PERIOD_W-1:0] period_cur,
  output logic                err_ovf
);

  localparam int PH_W = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;
  localparam int SW   = TIME_W + PERIOD_W + 2;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(N_PHASE - 1);

  logic [TIME_W-1:0]     time_r;
  logic [PH_W-1:0]       phase;
  logic [PERIOD_W-1:0]   pending;
  logic [PERIOD_W-1:0]   pend_nxt;
  logic [PERIOD_W-1:0]   step;
  logic [PERIOD_W-1:0]   load_val;
  logic [PERIOD_W:0]     p_up;
  logic [PERIOD_W:0]     p_dn_lim;
  logic signed [SW-1:0]  jit;
  logic signed [SW-1:0]  eff_raw;
  logic [TIME_W-1:0]     eff;
  logic [TIME_W:0]       sum;
  logic [N_PHASE-1:0]    edge_r;
  logic                  fire;
  logic                  wrap;
  logic                  unused_hi;

  // A disabled clock reports all-ones so it never wins the minimum
  assign time_eq    = en && (time_r == time_next);
  assign fire       = time_eq;
  assign wrap       = fire && (phase == PH_LAST);
  assign time_clock = en ? time_r : '1;
  assign phase_edge = en ? edge_r : '0;

  assign step = PERIOD_W'(phase_step(32'(period_cur),
                                     32'(phase),
                                     32'(N_PHASE)));

  jitter_lfsr #(
    .JITTER_W (JITTER_W),
    .SEED     (LFSR_SEED),
    .OUT_W    (SW)
  ) u_jit (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .adv     (fire),
    .jit     (jit)
  );

  // Negative jitter may not stall or reverse time
  always_comb begin
    eff_raw = $signed(SW'(step)) + jit;
    if (eff_raw < $signed(SW'(1))) begin
      eff = TIME_W'(1);
    end else begin
      eff = eff_raw[TIME_W-1:0];
    end
    sum = {1'b0, time_r} + {1'b0, eff};
  end

  assign unused_hi = ^eff_raw[SW-1:TIME_W];

  always_comb begin
    if (period_val < PERIOD_MIN) begin
      load_val = PERIOD_MIN;
    end else if (period_val > PERIOD_MAX) begin
      load_val = PERIOD_MAX;
    end else begin
      load_val = period_val;
    end
  end

  always_comb begin
    p_up     = {1'b0, pending} + {1'b0, STEP};
    p_dn_lim = {1'b0, PERIOD_MIN} + {1'b0, STEP};
    pend_nxt = pending;
    unique case (1'b1)
      period_load: begin
        pend_nxt = load_val;
      end
      (!period_load && up && !dn): begin
        if (p_up > {1'b0, PERIOD_MAX}) begin
          pend_nxt = PERIOD_MAX;
        end else begin
          pend_nxt = p_up[PERIOD_W-1:0];
        end
      end
      (!period_load && dn && !up): begin
        if ({1'b0, pending} < p_dn_lim) begin
          pend_nxt = PERIOD_MIN;
        end else begin
          pend_nxt = pending - STEP;
        end
      end
      default: begin
        pend_nxt = pending;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      time_r     <= TIME_INIT;
      phase      <= '0;
      period_cur <= PERIOD_INIT;
      pending    <= PERIOD_INIT;
      edge_r     <= '0;
      err_ovf    <= 1'b0;
    end else begin
      pending <= pend_nxt;
      edge_r  <= '0;
      if (fire) begin
        time_r <= sum[TIME_W-1:0];
        phase  <= (phase == PH_LAST) ? '0 : phase + 1'b1;
        edge_r <= N_PHASE'(1) << phase;
        if (sum[TIME_W]) begin
          err_ovf <= 1'b1;
        end
      end
      // Period only switches at a period boundary
      if (wrap) begin
        period_cur <= pending;
      end
    end
  end

endmodule

// File: tb/tb_dco_clock.sv
// tb_dco_clock: three dco_clock instances against a cycle model,
// plus hand-computed literal checks.
module tb_dco_clock;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        up = 1'b0;
  logic        dn = 1'b0;
  logic        period_load = 1'b0;
  logic        follow = 1'b1;
  logic [15:0] period_val = '0;
  logic [31:0] tn_man = '0;

  logic [31:0] tc_a, tn_a, tc_b, tn_b, tc_c, tn_c;
  logic        eq_a, eq_b, eq_c;
  logic [1:0]  ed_a, ed_c;
  logic [3:0]  ed_b;
  logic [15:0] pc_a, pc_b, pc_c;
  logic        ovf_a, ovf_b, ovf_c;

  assign tn_a = follow ? tc_a : tn_man;
  assign tn_b = follow ? tc_b : tn_man;
  assign tn_c = follow ? tc_c : tn_man;

  dco_clock u_a (
    .clk_sys(clk_sys), .rst_n(rst_n), .en(en),
    .time_next(tn_a), .up(up), .dn(dn),
    .period_load(period_load), .period_val(period_val),
    .time_clock(tc_a), .time_eq(eq_a), .phase_edge(ed_a),
    .period_cur(pc_a), .err_ovf(ovf_a)
  );

  dco_clock #(
    .N_PHASE(4), .PERIOD_INIT(16'd1001)
  ) u_b (
    .clk_sys(clk_sys), .rst_n(rst_n), .en(en),
    .time_next(tn_b), .up(up), .dn(dn),
    .period_load(period_load), .period_val(period_val),
    .time_clock(tc_b), .time_eq(eq_b), .phase_edge(ed_b),
    .period_cur(pc_b), .err_ovf(ovf_b)
  );

  dco_clock #(
    .N_PHASE(2), .PERIOD_INIT(16'd2), .PERIOD_MIN(16'd2),
    .PERIOD_MAX(16'd4), .JITTER_W(4),
    .TIME_INIT(32'hFFFF_FFC0)
  ) u_c (
    .clk_sys(clk_sys), .rst_n(rst_n), .en(en),
    .time_next(tn_c), .up(up), .dn(dn),
    .period_load(period_load), .period_val(period_val),
    .time_clock(tc_c), .time_eq(eq_c), .phase_edge(ed_c),
    .period_cur(pc_c), .err_ovf(ovf_c)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input longint exp);
    logic [63:0] e;
    e = exp;
    checks++;
    if (act === e) passes++;
    else $display("FAIL %s got %0h want %0h", nm, act, e);
  endtask

  typedef struct {
    longint t;
    int     ph;
    int     per;
    int     pend;
    int     lf;
    bit     ovf;
    int     ed;
    int     n;
    int     pmin;
    int     pmax;
    int     jw;
    longint tinit;
    int     pinit;
  } mdl_t;

  mdl_t ma, mb, mc;
  bit   mvalid = 1'b0;

  function automatic mdl_t mk(int n, int pinit, int pmin,
                              int pmax, int jw, longint tinit);
    mdl_t m;
    m.n = n; m.pinit = pinit; m.pmin = pmin; m.pmax = pmax;
    m.jw = jw; m.tinit = tinit;
    m.t = tinit; m.ph = 0; m.per = pinit; m.pend = pinit;
    m.lf = 'hACE1; m.ovf = 0; m.ed = 0;
    return m;
  endfunction

  // Edge k of a period sits at k*floor(P/N); the last edge closes P.
  function automatic mdl_t mstep(mdl_t m, bit r, bit e, bit f,
                                 bit u, bit d, bit l, int v,
                                 longint tm);
    mdl_t   o;
    longint tn, nt;
    int     stp, j, req;
    o = m;
    if (!r) begin
      o.t = m.tinit; o.ph = 0; o.per = m.pinit; o.pend = m.pinit;
      o.ed = 0; o.ovf = 0; o.lf = 'hACE1;
      return o;
    end
    tn = f ? (e ? m.t : 64'hFFFF_FFFF) : tm;
    req = m.pend;
    if (l) req = (v < m.pmin) ? m.pmin : (v > m.pmax) ? m.pmax : v;
    else if (u && !d) req = (m.pend + 1 > m.pmax) ? m.pmax : m.pend + 1;
    else if (d && !u) req = (m.pend - 1 < m.pmin) ? m.pmin : m.pend - 1;
    o.pend = req;
    o.ed = 0;
    if (e && tn == m.t) begin
      if (m.ph == m.n - 1) stp = m.per - (m.n - 1) * (m.per / m.n);
      else stp = m.per / m.n;
      j = 0;
      if (m.jw > 0) begin
        j = m.lf % (1 << m.jw);
        if (j >= (1 << (m.jw - 1))) j -= (1 << m.jw);
      end
      stp += j;
      if (stp < 1) stp = 1;
      nt = m.t + stp;
      if (nt >= 64'h1_0000_0000) begin
        o.ovf = 1;
        nt -= 64'h1_0000_0000;
      end
      o.t = nt;
      o.ph = (m.ph + 1) % m.n;
      o.ed = 1 << m.ph;
      o.lf = (m.lf & 1) ? ((m.lf >> 1) ^ 'hB400) : (m.lf >> 1);
      if (m.ph == m.n - 1) o.per = m.pend;
    end
    return o;
  endfunction

  always @(posedge clk_sys) begin
    ma = mstep(ma, rst_n, en, follow, up, dn, period_load,
               int'(period_val), longint'(tn_man));
    mb = mstep(mb, rst_n, en, follow, up, dn, period_load,
               int'(period_val), longint'(tn_man));
    mc = mstep(mc, rst_n, en, follow, up, dn, period_load,
               int'(period_val), longint'(tn_man));
    if (!rst_n) mvalid = 1'b1;
  end

  task automatic cmp(input string nm, input mdl_t m,
                     input logic [31:0] tc, input logic eq,
                     input logic [7:0] ed, input logic [15:0] pc,
                     input logic ovf);
    longint tn;
    tn = follow ? (en ? m.t : 64'hFFFF_FFFF) : longint'(tn_man);
    chk({nm, ".time_clock"}, 64'(tc), en ? m.t : 64'hFFFF_FFFF);
    chk({nm, ".time_eq"}, 64'(eq), longint'(en && tn == m.t));
    chk({nm, ".edge"}, 64'(ed), en ? m.ed : 0);
    chk({nm, ".period_cur"}, 64'(pc), m.per);
    chk({nm, ".err_ovf"}, 64'(ovf), m.ovf);
  endtask

  always @(negedge clk_sys) begin
    if (mvalid) begin
      cmp("A", ma, tc_a, eq_a, {6'b0, ed_a}, pc_a, ovf_a);
      cmp("B", mb, tc_b, eq_b, {4'b0, ed_b}, pc_b, ovf_b);
      cmp("C", mc, tc_c, eq_c, {6'b0, ed_c}, pc_c, ovf_c);
    end
  end

  task automatic cyc(input logic r, input logic e, input logic u,
                     input logic d, input logic l,
                     input logic [15:0] v);
    rst_n = r; en = e; up = u; dn = d;
    period_load = l; period_val = v;
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    ma = mk(2, 1000, 900, 1100, 0, 0);
    mb = mk(4, 1001, 900, 1100, 0, 0);
    mc = mk(2, 2, 2, 4, 4, 64'hFFFF_FFC0);

    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("rst.A.tc", 64'(tc_a), 0);
    chk("rst.A.period", 64'(pc_a), 1000);
    chk("rst.A.edge", 64'(ed_a), 0);
    chk("rst.A.ovf", 64'(ovf_a), 0);
    chk("rst.C.tc", 64'(tc_c), 64'hFFFF_FFC0);

    cyc(1, 1, 0, 0, 0, 0);
    chk("f1.A.tc", 64'(tc_a), 500);
    chk("f1.A.edge", 64'(ed_a), 1);
    chk("f1.B.tc", 64'(tc_b), 250);
    cyc(1, 1, 0, 0, 0, 0);
    chk("f2.A.tc", 64'(tc_a), 1000);
    chk("f2.A.edge", 64'(ed_a), 2);
    cyc(1, 1, 0, 0, 0, 0);
    chk("f3.A.tc", 64'(tc_a), 1500);
    chk("f3.B.tc", 64'(tc_b), 750);
    cyc(1, 1, 0, 0, 0, 0);
    chk("f4.B.tc", 64'(tc_b), 1001);
    chk("f4.B.edge", 64'(ed_b), 8);

    cyc(1, 1, 1, 0, 0, 0);
    chk("up.ph0.A.period", 64'(pc_a), 1000);
    cyc(1, 1, 1, 1, 0, 0);
    chk("updn.wrap.A.period", 64'(pc_a), 1001);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    chk("up.onwrap.A.period", 64'(pc_a), 1001);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("next.wrap.A.period", 64'(pc_a), 1002);

    for (int i = 0; i < 150; i++) cyc(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0);
    chk("sat.A.period", 64'(pc_a), 1100);
    chk("sat.B.period", 64'(pc_b), 1100);
    chk("early.C.ovf", 64'(ovf_c), 1);

    cyc(1, 1, 0, 0, 1, 16'd850);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0);
    chk("load850.A.period", 64'(pc_a), 900);
    chk("load850.C.period", 64'(pc_c), 4);
    cyc(1, 1, 1, 0, 1, 16'd2000);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0);
    chk("load2000.A.period", 64'(pc_a), 1100);
    for (int i = 0; i < 210; i++) cyc(1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0);
    chk("dnsat.A.period", 64'(pc_a), 900);
    chk("dnsat.C.period", 64'(pc_c), 2);

    follow = 1'b0;
    tn_man = 32'd5;
    cyc(1, 1, 0, 0, 0, 0);
    chk("nomatch.A.eq", 64'(eq_a), 0);
    cyc(1, 1, 0, 0, 0, 0);
    follow = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      chk("dis.A.tc", 64'(tc_a), 64'hFFFF_FFFF);
      chk("dis.A.eq", 64'(eq_a), 0);
    end
    chk("dis.B.edge", 64'(ed_b), 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0);

    chk("sticky.C.ovf", 64'(ovf_c), 1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("rst2.C.ovf", 64'(ovf_c), 0);
    chk("rst2.C.tc", 64'(tc_c), 64'hFFFF_FFC0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("seed1.C.tc", 64'(tc_c), 64'hFFFF_FFC2);
    cyc(1, 1, 0, 0, 0, 0);
    chk("seed2.C.tc", 64'(tc_c), 64'hFFFF_FFC3);
    cyc(1, 1, 0, 0, 0, 0);
    chk("clamp1.C.tc", 64'(tc_c), 64'hFFFF_FFC4);
    cyc(1, 1, 0, 0, 0, 0);
    chk("clamp2.C.tc", 64'(tc_c), 64'hFFFF_FFC5);
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0, 0, 0);

    @(negedge clk_sys);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dco_clock.md
Name: dco_clock

Overview:
- Parametrised successor to the fixed-increment clock generator in the event-driven link emulator.
- Produces N_PHASE evenly spaced edges per period in emulated time, for example the RX p/n sampling phases.
- The period can be adjusted at runtime by CDR up/dn pulses or by a direct load, and per-edge LFSR jitter can be added.
- Sits on clk_sys beside the time manager: it publishes its next edge time, and fires when the global time_next reaches it.

Parameters:
TIME_W, 32, width of emulated-time words (unsigned fixed point, shared with time manager)
PERIOD_W, 16, width of period register, in TIME_W LSBs
N_PHASE, 2, edges per period; power of two, 1..8
PERIOD_INIT, 16'd1000, period after reset
PERIOD_MIN, 16'd900, lower saturation bound
PERIOD_MAX, 16'd1100, upper saturation bound
STEP, 16'd1, period change per accepted up/dn
JITTER_W, 0, bits of signed per-edge jitter; 0 disables the LFSR entirely
LFSR_SEED, 16'hACE1, nonzero LFSR reset value
TIME_INIT, 0, time of first edge after reset

Ports:
clk_sys  in  1  system clock; all state updates on its rising edge
rst_n  in  1  reset, synchronous active-low
en  in  1  clock enable; low = clock frozen
time_next  in  TIME_W  global next event time from time manager
up  in  1  CDR request: lengthen period by STEP
dn  in  1  CDR request: shorten period by STEP
period_load  in  1  load period_val
period_val  in  PERIOD_W  direct period value
time_clock  out  TIME_W  time of this block's next edge (to time manager)
time_eq  out  1  combinational: en & (time_clock == time_next)
edge  out  N_PHASE  registered one-hot strobe of the phase that fired last cycle
period_cur  out  PERIOD_W  active period
err_ovf  out  1  sticky: time_clock addition overflowed

Behaviour:
Reset (rst_n low at clk_sys edge) sets:
- time_clock register = TIME_INIT
- phase = 0
- period_cur = PERIOD_INIT
- pending period = PERIOD_INIT
- edge = 0
- err_ovf = 0
- lfsr = LFSR_SEED

Reset mid-operation discards any pending period change.

Disabled clock:
- With en = 0, the time_clock output is driven to all-ones so the disabled clock never holds back the global minimum.
- Internal state is held.
- time_eq = 0 and edge = 0.

Firing, on a cycle with time_eq = 1:
- time_clock <= time_clock + step(phase) + jit.
- phase <= (phase + 1) mod N_PHASE.
- edge <= one-hot(phase) for exactly one cycle. Latency from time_eq to edge is 1 cycle.

Step arithmetic:
- base = period_cur >> log2(N_PHASE).
- Phases 0..N_PHASE-2 use base. Phase N_PHASE-1 uses period_cur - (N_PHASE-1)*base, so the sum over one period is exactly period_cur.
- jit is the low JITTER_W bits of lfsr, interpreted as signed and sign-extended.
- The effective step is clamped to a minimum of 1, so time is strictly monotonic.
- The LFSR (x^16+x^14+x^13+x^11+1) advances only on firing cycles.

Period control:
- Requests are captured into the pending register on any cycle.
- period_load has priority over up/dn; its value is clamped to [PERIOD_MIN, PERIOD_MAX].
- up & dn together is no change; up alone adds STEP; dn alone subtracts STEP; the result saturates at the bounds.
- Multiple requests within one period accumulate, each applied to the current pending value.
- pending is copied to period_cur only on the firing of phase N_PHASE-1, so a period is never split between two values. A request arriving on that same cycle lands in pending for the following period.

Overflow:
- If the time_clock addition carries out of TIME_W, err_ovf is set and stays set until reset.
- The time value wraps modulo 2^TIME_W.

Decomposition:
- Package clock_settings holds:
  - TIME_FORMAT and PERIOD_FORMAT typedefs, matching TIME_W/PERIOD_W;
  - the LFSR polynomial constant;
  - a default-period constant per link rate;
  - a function computing phase step from (period, phase, N_PHASE).
- One sub-module, jitter_lfsr: 16-bit Galois LFSR with advance enable and a signed JITTER_W output. It is bypassed (constant 0) when JITTER_W = 0.

Test Plan:
1. Reset, en=1, N_PHASE=2, period 1000, JITTER_W=0, time_next driven = time_clock each cycle -> time_clock sequence 0, 500, 1000, 1500; edge alternates 01, 10; period_cur = 1000.
2. Period 1001, N_PHASE=4 -> steps 250, 250, 250, 251; time_clock after 4 firings = 1001.
3. up pulsed during phase 0, then dn+up together -> period_cur becomes 1001 only after phase N-1 fires; the simultaneous pair is no-op. Drive up 150 times -> period saturates at 1100.
4. period_load=2000 with up on the same cycle -> pending = 1100 (clamped; load wins); applied at the next wrap.
5. en=0 for 10 cycles -> time_clock out = 32'hFFFFFFFF, time_eq=0, edge=0, state unchanged; en=1 resumes at the held time.
6. JITTER_W=4, step 1, TIME_INIT near 2^32-1 -> effective step never < 1; on the wrap err_ovf rises and stays 1; rst_n low for one cycle clears it and restores the LFSR seed sequence.
